// File: rtl/quad_zero_cross.sv
// Root-bracket detector for a sampled quadratic sweep: flags sign changes / exact zeros of y,
// queues (x_lo, x_hi, exact) events in a FWFT FIFO, and tracks the sweep minimum of y.
module quad_zero_cross #(
  parameter int W          = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [W-1:0]     x_in,
  input  logic [W-1:0]     y_in,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [W-1:0]     ev_x_lo,
  output logic [W-1:0]     ev_x_hi,
  output logic             ev_exact,
  output logic [CNT_W-1:0] cross_cnt,
  output logic [W-1:0]     y_min,
  output logic [W-1:0]     x_at_min,
  output logic             overflow,
  output logic             busy,
  output logic             done
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] x_lo;
    logic [W-1:0] x_hi;
    logic         exact;
  } ev_t;

  state_t        state, nstate;
  ev_t           mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   occ;
  logic [W-1:0]  prev_x, prev_y;

  logic samp, ev_hit, full, pop, wr_en;

  // Sample is consumed only while sweeping; a start on the same cycle wins.
  assign samp   = in_valid && !start && (state == PRIME || state == RUN);
  // With prev_y nonzero, either y_in is zero or a differing sign bit is a strict crossing.
  assign ev_hit = samp && (state == RUN) && (prev_y != '0) &&
                  ((y_in == '0) || (prev_y[W-1] != y_in[W-1]));
  assign full   = (occ == (AW+1)'(FIFO_DEPTH));
  assign pop    = ev_valid && ev_ready && !start;
  assign wr_en  = ev_hit && (!full || pop);

  always_comb begin
    nstate = state;
    if (start) nstate = PRIME;
    else begin
      case (state)
        PRIME, RUN: if (in_valid) nstate = in_last ? DONE : RUN;
        default:    nstate = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || start) begin
      state     <= reset ? IDLE : PRIME;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      prev_x    <= '0;
      prev_y    <= '0;
      cross_cnt <= '0;
      y_min     <= {1'b0, {(W-1){1'b1}}};
      x_at_min  <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= nstate;
      if (samp) begin
        prev_x <= x_in;
        prev_y <= y_in;
        if ($signed(y_in) < $signed(y_min)) begin
          y_min    <= y_in;
          x_at_min <= x_in;
        end
      end
      if (ev_hit) begin
        if (cross_cnt != '1) cross_cnt <= cross_cnt + CNT_W'(1);
        if (!wr_en) overflow <= 1'b1;
      end
      // When full with a pop, wr_ptr==rd_ptr: the slot being vacated takes the new event.
      if (wr_en) begin
        mem[wr_ptr] <= '{x_lo: prev_x, x_hi: x_in, exact: (y_in == '0)};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  assign ev_valid = (occ != '0);
  assign ev_x_lo  = mem[rd_ptr].x_lo;
  assign ev_x_hi  = mem[rd_ptr].x_hi;
  assign ev_exact = mem[rd_ptr].exact;
  assign busy     = (state == PRIME) || (state == RUN);
  assign done     = (state == DONE);
endmodule

// File: tb/tb_quad_zero_cross.sv
// Bench for quad_zero_cross: queue-based reference model checked every cycle,
// plus literal expectations for the directed sweeps.
module tb_quad_zero_cross;
  localparam int W = 10, D = 4, CW = 8;

  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0, ev_ready = 0;
  logic [W-1:0] x_in = '0, y_in = '0;
  logic ev_valid, ev_exact, overflow, busy, done;
  logic [W-1:0] ev_x_lo, ev_x_hi, y_min, x_at_min;
  logic [CW-1:0] cross_cnt;

  quad_zero_cross #(.W(W), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_last(in_last),
    .x_in(x_in), .y_in(y_in), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x_lo(ev_x_lo), .ev_x_hi(ev_x_hi), .ev_exact(ev_exact), .cross_cnt(cross_cnt),
    .y_min(y_min), .x_at_min(x_at_min), .overflow(overflow), .busy(busy), .done(done));

  always #5 clk = ~clk;

  typedef struct { int lo; int hi; int ex; } mev_t;
  mev_t q[$];
  mev_t plog[$];
  int mphase;  // 0 idle, 1 prime, 2 run, 3 done
  int m_px, m_py, m_ymin, m_xmin, m_cnt, m_ovf;
  int checks = 0, errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic mclear();
    q.delete(); m_px = 0; m_py = 0; m_ymin = 511; m_xmin = 0; m_cnt = 0; m_ovf = 0;
  endtask

  // Reference model, evaluated on each rising edge from the inputs seen there.
  always @(posedge clk) begin
    int xi, yi;
    xi = sx(x_in); yi = sx(y_in);
    if (reset) begin mclear(); mphase = 0; end
    else if (start) begin mclear(); mphase = 1; end
    else begin
      if (q.size() > 0 && ev_ready) void'(q.pop_front());
      if (in_valid && (mphase == 1 || mphase == 2)) begin
        if (mphase == 2 && m_py != 0 && (yi == 0 || m_py * yi < 0)) begin
          if (m_cnt < 255) m_cnt++;
          if (q.size() < D) q.push_back('{m_px, xi, (yi == 0)});
          else m_ovf = 1;
        end
        if (yi < m_ymin) begin m_ymin = yi; m_xmin = xi; end
        m_px = xi; m_py = yi;
        mphase = in_last ? 3 : 2;
      end
    end
    chk_en <= 1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ev_valid", ev_valid, q.size() > 0);
      if (q.size() > 0 && ev_valid) begin
        chk("ev_x_lo", sx(ev_x_lo), q[0].lo);
        chk("ev_x_hi", sx(ev_x_hi), q[0].hi);
        chk("ev_exact", ev_exact, q[0].ex);
      end
      chk("cross_cnt", cross_cnt, m_cnt);
      chk("y_min", sx(y_min), m_ymin);
      chk("x_at_min", sx(x_at_min), m_xmin);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, mphase == 1 || mphase == 2);
      chk("done", done, mphase == 3);
      if (ev_valid && ev_ready)
        plog.push_back('{sx(ev_x_lo), sx(ev_x_hi), int'(ev_exact)});
    end
  end

  task automatic drv(input bit v, input int x, input int y, input bit last, input bit st,
                     input bit rdy);
    in_valid = v; x_in = W'(x); y_in = W'(y); in_last = last; start = st; ev_ready = rdy;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0; start = 0;
  endtask

  int ys3[6] = '{5, -3, 7, -1, 2, -4};
  int ys4[5] = '{1, -1, 1, -1, 1};
  int ys5[4] = '{3, 0, 0, -2};

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0;
    // 1: idle with in_valid pulses
    for (int i = 0; i < 5; i++) drv(1, i, -i - 1, 0, 0, 0);
    chk("t1_ev_valid", ev_valid, 0);
    chk("t1_cnt", cross_cnt, 0);
    chk("t1_ymin", sx(y_min), 511);
    chk("t1_busy", busy, 0);

    // 2: parabola sweep
    drv(0, 0, 0, 0, 1, 1);
    plog.delete();
    for (int x = -64; x <= 64; x += 8) drv(1, x, x * x / 32 - 32, x == 64, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1);
    chk("t2_nev", plog.size(), 2);
    if (plog.size() == 2) begin
      chk("t2_e0_lo", plog[0].lo, -40); chk("t2_e0_hi", plog[0].hi, -32);
      chk("t2_e0_ex", plog[0].ex, 1);
      chk("t2_e1_lo", plog[1].lo, 24);  chk("t2_e1_hi", plog[1].hi, 32);
      chk("t2_e1_ex", plog[1].ex, 1);
    end
    chk("t2_cnt", cross_cnt, 2);
    chk("t2_ymin", y_min, 10'h3E0);
    chk("t2_xmin", sx(x_at_min), 0);
    chk("t2_done", done, 1);

    // 3: overflow with ev_ready low, then drain
    drv(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) drv(1, i, ys3[i], i == 5, 0, 0);
    chk("t3_ovf", overflow, 1);
    chk("t3_cnt", cross_cnt, 5);
    plog.delete();
    for (int i = 0; i < 6; i++) drv(0, 0, 0, 0, 0, 1);
    chk("t3_nev", plog.size(), 4);
    for (int i = 0; i < plog.size() && i < 4; i++) begin
      chk("t3_lo", plog[i].lo, i);
      chk("t3_ex", plog[i].ex, 0);
    end

    // 4: full FIFO, push and pop together
    drv(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) drv(1, i, ys4[i], 0, 0, 0);
    drv(1, 5, -1, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0);
    chk("t4_ovf", overflow, 0);
    chk("t4_cnt", cross_cnt, 5);
    plog.delete();
    for (int i = 0; i < 6; i++) drv(0, 0, 0, 0, 0, 1);
    chk("t4_nev", plog.size(), 4);
    for (int i = 0; i < plog.size() && i < 4; i++) chk("t4_lo", plog[i].lo, i + 1);

    // 5: zeros, then restart mid-RUN
    drv(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drv(1, i, ys5[i], 0, 0, 0);
    chk("t5_cnt", cross_cnt, 1);
    chk("t5_lo", sx(ev_x_lo), 0);
    chk("t5_hi", sx(ev_x_hi), 1);
    chk("t5_ex", ev_exact, 1);
    drv(1, 9, -5, 0, 1, 0);
    chk("t5_rst_cnt", cross_cnt, 0);
    chk("t5_rst_ev", ev_valid, 0);
    chk("t5_rst_busy", busy, 1);
    chk("t5_rst_ymin", sx(y_min), 511);
    drv(1, 0, 4, 0, 0, 0);
    drv(1, 1, -4, 0, 0, 0);
    drv(1, 2, 4, 0, 0, 0);

    // 6: reset mid-sweep with events queued
    chk("t6_pre_ev", ev_valid, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("t6_ev", ev_valid, 0);
    chk("t6_lo", ev_x_lo, 0);
    chk("t6_hi", ev_x_hi, 0);
    chk("t6_ex", ev_exact, 0);
    chk("t6_cnt", cross_cnt, 0);
    chk("t6_ymin", y_min, 10'h1FF);
    chk("t6_xmin", x_at_min, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    drv(1, 3, -7, 0, 0, 0);
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_ymin", sx(y_min), 511);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
